// File: rtl/seg7_bcd_stopwatch_if.sv
// Key inputs and display outputs of the BCD stopwatch.
// Optional lap key present when SEG7_LAP_EN is defined.
interface seg7_bcd_stopwatch_if;
  logic        iKEY_RUN_N;
  logic        iKEY_CLR_N;
  logic        iUP;
`ifdef SEG7_LAP_EN
  logic        iKEY_LAP_N;
`endif
  logic [31:0] oDIG;
  logic        oTICK;
  logic        oWRAP;
  logic        oRUN;

  // Stopwatch side: consumes keys, produces the digit word.
  modport slave (
    input  iKEY_RUN_N,
    input  iKEY_CLR_N,
    input  iUP,
`ifdef SEG7_LAP_EN
    input  iKEY_LAP_N,
`endif
    output oDIG,
    output oTICK,
    output oWRAP,
    output oRUN
  );

  // Board / driver side.
  modport master (
    output iKEY_RUN_N,
    output iKEY_CLR_N,
    output iUP,
`ifdef SEG7_LAP_EN
    output iKEY_LAP_N,
`endif
    input  oDIG,
    input  oTICK,
    input  oWRAP,
    input  oRUN
  );
endinterface

// File: rtl/seg7_bcd_stopwatch.sv
// 8-digit BCD up/down stopwatch feeding the SEG7_LUT_8 digit word.
// Keys are synchronized and debounced; press events drive an IDLE/RUN/PAUSE FSM.
// Optional lap freeze of the displayed value enabled by macro SEG7_LAP_EN.
module seg7_bcd_stopwatch #(
  parameter int unsigned TICK_DIV  = 5000000,
  parameter int unsigned DB_CYCLES = 1000000
) (
  input  logic                  CLOCK_50,
  input  logic                  iRST_N,
  seg7_bcd_stopwatch_if.slave   io_sw
);

`ifdef SEG7_LAP_EN
  localparam int unsigned NumKeys = 3;
`else
  localparam int unsigned NumKeys = 2;
`endif
  localparam int unsigned DbW = $clog2(DB_CYCLES + 1);
  localparam int unsigned PsW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  logic [NumKeys-1:0] w_keys_raw;
  logic [NumKeys-1:0] r_sync1;
  logic [NumKeys-1:0] r_sync2;
  logic [NumKeys-1:0] r_db;
  logic [NumKeys-1:0] r_press;
  logic [DbW-1:0]     r_db_cnt [NumKeys];
  logic               r_up_s1;
  logic               r_up_s2;

  logic               w_run_press;
  logic               w_clr_press;
  state_e             r_state;
  state_e             w_state_next;

  logic [PsW-1:0]     r_presc;
  logic               w_step;
  logic [31:0]        r_cnt;
  logic [31:0]        w_cnt_next;
  logic               w_carry;
  logic [3:0]         w_nib;
  logic               r_tick;
  logic               r_wrap;

`ifdef SEG7_LAP_EN
  assign w_keys_raw = {io_sw.iKEY_LAP_N, io_sw.iKEY_CLR_N, io_sw.iKEY_RUN_N};
`else
  assign w_keys_raw = {io_sw.iKEY_CLR_N, io_sw.iKEY_RUN_N};
`endif
  assign w_run_press = r_press[0];
  assign w_clr_press = r_press[1];

  // Two-flop synchronizers; idle (released / count up) level is 1.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_up_s1 <= 1'b1;
      r_up_s2 <= 1'b1;
    end else begin
      r_sync1 <= w_keys_raw;
      r_sync2 <= r_sync1;
      r_up_s1 <= io_sw.iUP;
      r_up_s2 <= r_up_s1;
    end
  end

  // Debounce: level flips after DB_CYCLES consecutive disagreeing cycles; press on 1->0 only.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_db    <= '1;
      r_press <= '0;
      for (int k = 0; k < NumKeys; k++) begin
        r_db_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NumKeys; k++) begin
        r_press[k] <= 1'b0;
        if (r_sync2[k] == r_db[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DbW'(DB_CYCLES - 1)) begin
          r_db[k]     <= r_sync2[k];
          r_db_cnt[k] <= '0;
          r_press[k]  <= r_db[k];
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + DbW'(1);
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; clear overrides a simultaneous run press.
  always_comb begin
    w_state_next = r_state;
    if (w_clr_press) begin
      w_state_next = StIdle;
    end else if (w_run_press) begin
      unique case (r_state)
        StIdle:  w_state_next = StRun;
        StRun:   w_state_next = StPause;
        StPause: w_state_next = StRun;
        default: w_state_next = StIdle;
      endcase
    end
  end

  assign w_step = (r_state == StRun) && (r_presc == PsW'(TICK_DIV - 1)) && !w_clr_press;

  // BCD ripple increment/decrement of all eight digits; final carry means wrap.
  always_comb begin
    w_cnt_next = r_cnt;
    w_carry    = 1'b1;
    w_nib      = 4'd0;
    for (int d = 0; d < 8; d++) begin
      w_nib = r_cnt[4*d +: 4];
      if (w_carry) begin
        if (r_up_s2) begin
          if (w_nib == 4'd9) begin
            w_nib = 4'd0;
          end else begin
            w_nib   = w_nib + 4'd1;
            w_carry = 1'b0;
          end
        end else begin
          if (w_nib == 4'd0) begin
            w_nib = 4'd9;
          end else begin
            w_nib   = w_nib - 4'd1;
            w_carry = 1'b0;
          end
        end
      end
      w_cnt_next[4*d +: 4] = w_nib;
    end
  end

  // Prescaler and live count; prescaler holds in PAUSE so resume keeps phase.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_presc <= '0;
      r_cnt   <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      if (w_clr_press) begin
        r_presc <= '0;
        r_cnt   <= '0;
      end else if (w_step) begin
        r_presc <= '0;
        r_cnt   <= w_cnt_next;
        r_tick  <= 1'b1;
        r_wrap  <= w_carry;
      end else if (r_state == StRun) begin
        r_presc <= r_presc + PsW'(1);
      end else if (r_state == StIdle) begin
        r_presc <= '0;
      end
    end
  end

`ifdef SEG7_LAP_EN
  logic        r_lap_on;
  logic [31:0] r_lap_dig;

  // Lap toggle accepted only in RUN; an active freeze survives PAUSE, clear drops it.
  always_ff @(posedge CLOCK_50 or negedge iRST_N) begin
    if (!iRST_N) begin
      r_lap_on  <= 1'b0;
      r_lap_dig <= '0;
    end else if (w_clr_press) begin
      r_lap_on <= 1'b0;
    end else if (r_press[2] && (r_state == StRun)) begin
      r_lap_on <= !r_lap_on;
      if (!r_lap_on) begin
        r_lap_dig <= r_cnt;
      end
    end
  end

  assign io_sw.oDIG = r_lap_on ? r_lap_dig : r_cnt;
`else
  assign io_sw.oDIG = r_cnt;
`endif

  assign io_sw.oTICK = r_tick;
  assign io_sw.oWRAP = r_wrap;
  assign io_sw.oRUN  = (r_state == StRun);

endmodule

// File: tb/tb_seg7_bcd_stopwatch.sv
// Directed bench for seg7_bcd_stopwatch with TICK_DIV=4, DB_CYCLES=3.
module tb_seg7_bcd_stopwatch;
  localparam int unsigned TickDiv  = 4;
  localparam int unsigned DbCycles = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  seg7_bcd_stopwatch_if sw_if ();

  seg7_bcd_stopwatch #(
    .TICK_DIV  (TickDiv),
    .DB_CYCLES (DbCycles)
  ) dut (
    .CLOCK_50 (clk),
    .iRST_N   (rst_n),
    .io_sw    (sw_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n clocks; return 1 time unit after the edge.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    do begin
      cyc(1);
      n++;
    end while (sw_if.oTICK !== 1'b1 && n < 64);
    chk(tag, {31'd0, sw_if.oTICK}, 32'd1);
  endtask

  task automatic wait_dig(input logic [31:0] v, input string tag);
    int n = 0;
    while (sw_if.oDIG !== v && n < 4000) begin
      cyc(1);
      n++;
    end
    chk(tag, sw_if.oDIG, v);
  endtask

  // Hold selected keys low for 6 cycles: event registered at cycle 5, FSM acts at cycle 6.
  task automatic press(input bit run, input bit clr, input bit lap);
    if (run) sw_if.iKEY_RUN_N = 1'b0;
    if (clr) sw_if.iKEY_CLR_N = 1'b0;
`ifdef SEG7_LAP_EN
    if (lap) sw_if.iKEY_LAP_N = 1'b0;
`else
    if (lap) sw_if.iKEY_RUN_N = sw_if.iKEY_RUN_N;
`endif
    cyc(6);
    sw_if.iKEY_RUN_N = 1'b1;
    sw_if.iKEY_CLR_N = 1'b1;
`ifdef SEG7_LAP_EN
    sw_if.iKEY_LAP_N = 1'b1;
`endif
  endtask

  initial begin
    int nt;
    sw_if.iKEY_RUN_N = 1'b1;
    sw_if.iKEY_CLR_N = 1'b1;
    sw_if.iUP        = 1'b1;
`ifdef SEG7_LAP_EN
    sw_if.iKEY_LAP_N = 1'b1;
`endif
    #2 rst_n = 1'b0;
    cyc(3);
    chk("rst_dig", sw_if.oDIG, 32'h0);
    chk("rst_run", {31'd0, sw_if.oRUN}, 32'd0);
    chk("rst_tick", {31'd0, sw_if.oTICK}, 32'd0);
    chk("rst_wrap", {31'd0, sw_if.oWRAP}, 32'd0);
    rst_n = 1'b1;
    cyc(100);
    chk("idle_dig", sw_if.oDIG, 32'h0);
    chk("idle_run", {31'd0, sw_if.oRUN}, 32'd0);

    // Run press held 10 cycles: RUN after 2+3+1, first step 4 cycles later.
    sw_if.iKEY_RUN_N = 1'b0;
    cyc(5);
    chk("run_lat5", {31'd0, sw_if.oRUN}, 32'd0);
    cyc(1);
    chk("run_lat6", {31'd0, sw_if.oRUN}, 32'd1);
    cyc(3);
    chk("first_tick_early", {31'd0, sw_if.oTICK}, 32'd0);
    cyc(1);
    chk("first_tick", {31'd0, sw_if.oTICK}, 32'd1);
    chk("first_dig", sw_if.oDIG, 32'h1);
    sw_if.iKEY_RUN_N = 1'b1;
    for (int i = 2; i <= 12; i++) begin
      cyc(4);
      chk("tick_period", {31'd0, sw_if.oTICK}, 32'd1);
    end
    chk("dig_12", sw_if.oDIG, 32'h12);
    wait_dig(32'h99, "dig_99");
    wait_tick("tick_100");
    chk("dig_100", sw_if.oDIG, 32'h100);
    chk("wrap_100", {31'd0, sw_if.oWRAP}, 32'd0);

    // Debounce glitches.
    sw_if.iKEY_RUN_N = 1'b0;
    cyc(2);
    sw_if.iKEY_RUN_N = 1'b1;
    cyc(10);
    chk("glitch2_run", {31'd0, sw_if.oRUN}, 32'd1);
    sw_if.iKEY_RUN_N = 1'b0;
    cyc(3);
    sw_if.iKEY_RUN_N = 1'b1;
    cyc(1);
    sw_if.iKEY_RUN_N = 1'b0;
    cyc(3);
    sw_if.iKEY_RUN_N = 1'b1;
    cyc(12);
    chk("glitch3_pause", {31'd0, sw_if.oRUN}, 32'd0);
    press(1'b0, 1'b1, 1'b0);
    cyc(10);
    chk("clr_dig", sw_if.oDIG, 32'h0);
    chk("clr_run", {31'd0, sw_if.oRUN}, 32'd0);

    // Count down from zero wraps to all nines.
    sw_if.iUP = 1'b0;
    cyc(3);
    press(1'b1, 1'b0, 1'b0);
    wait_tick("down_tick1");
    chk("down_dig1", sw_if.oDIG, 32'h99999999);
    chk("down_wrap1", {31'd0, sw_if.oWRAP}, 32'd1);
    wait_tick("down_tick2");
    chk("down_dig2", sw_if.oDIG, 32'h99999998);
    chk("down_wrap2", {31'd0, sw_if.oWRAP}, 32'd0);
    press(1'b0, 1'b1, 1'b0);
    cyc(10);
    sw_if.iUP = 1'b1;
    cyc(3);

    // Pause at 5 (the 5th step lands during the press), then run+clear together.
    press(1'b1, 1'b0, 1'b0);
    repeat (4) wait_tick("pause_pre_tick");
    chk("pause_pre_dig", sw_if.oDIG, 32'h4);
    press(1'b1, 1'b0, 1'b0);
    nt = 0;
    repeat (50) begin
      cyc(1);
      if (sw_if.oTICK === 1'b1) nt++;
    end
    chk("pause_ticks", nt, 32'd0);
    chk("pause_dig", sw_if.oDIG, 32'h5);
    chk("pause_run", {31'd0, sw_if.oRUN}, 32'd0);
    press(1'b1, 1'b1, 1'b0);
    cyc(4);
    chk("both_run", {31'd0, sw_if.oRUN}, 32'd0);
    chk("both_dig", sw_if.oDIG, 32'h0);

`ifdef SEG7_LAP_EN
    // Lap freeze at 20 while eight live steps pass, then release shows 28.
    cyc(10);
    press(1'b1, 1'b0, 1'b0);
    wait_dig(32'h19, "lap_pre");
    press(1'b0, 1'b0, 1'b1);
    chk("lap_frz", sw_if.oDIG, 32'h20);
    for (int i = 0; i < 7; i++) begin
      wait_tick("lap_tick");
      chk("lap_hold", sw_if.oDIG, 32'h20);
    end
    press(1'b0, 1'b0, 1'b1);
    chk("lap_rel", sw_if.oDIG, 32'h28);
    press(1'b0, 1'b1, 1'b0);
`endif

    // Asynchronous reset mid-count at 37.
    cyc(10);
    press(1'b1, 1'b0, 1'b0);
    wait_dig(32'h37, "pre_rst_dig");
    #3 rst_n = 1'b0;
    #1;
    chk("arst_dig", sw_if.oDIG, 32'h0);
    chk("arst_run", {31'd0, sw_if.oRUN}, 32'd0);
    chk("arst_tick", {31'd0, sw_if.oTICK}, 32'd0);
    cyc(1);
    rst_n = 1'b1;
    cyc(100);
    chk("post_rst_dig", sw_if.oDIG, 32'h0);
    chk("post_rst_run", {31'd0, sw_if.oRUN}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/seg7_bcd_stopwatch.md
Name: seg7_bcd_stopwatch

Overview:
- 8-digit BCD up/down stopwatch counter; generates the packed 32-bit digit word consumed by SEG7_LUT_8 (iDIG).
- Sits directly upstream of the 7-segment LUT stage; replaces a free-running binary counter, so every nibble is always a legal 0-9 digit.
- Run/pause and clear come from raw DE2 pushbuttons; direction comes from a slide switch.

Parameters:
- TICK_DIV, 5000000, CLOCK_50 cycles per count step (10 Hz at 50 MHz); legal range >= 2.
- DB_CYCLES, 1000000, consecutive stable cycles required to accept a key level change (20 ms); legal range >= 1.

Ports:
- CLOCK_50  input  1  system clock, 50 MHz.
- iRST_N  input  1  asynchronous, active-low reset.
- iKEY_RUN_N  input  1  raw pushbutton, active-low; each press toggles run/pause.
- iKEY_CLR_N  input  1  raw pushbutton, active-low; each press clears to zero and stops.
- iUP  input  1  raw switch level: 1 = count up, 0 = count down.
- oDIG  output  32  8 BCD digits; digit0 (least significant) at [3:0], digit7 at [31:28].
- oTICK  output  1  one-cycle pulse in the cycle oDIG takes a new count value.
- oWRAP  output  1  one-cycle pulse coincident with oTICK when the count wraps.
- oRUN  output  1  1 while in RUN state.

Behaviour:
- Reset (asynchronous, iRST_N low): oDIG=0, oTICK=0, oWRAP=0, oRUN=0, prescaler=0, state=IDLE. Synchronizer flops and debounced key levels reset to 1 (released). Reset asserted mid-count clears immediately, with no wait for the clock edge.
- Input conditioning: iKEY_RUN_N, iKEY_CLR_N and iUP each pass through a 2-flop synchronizer. The keys are then debounced:
  - A per-key counter increments while the synchronized level differs from the debounced level.
  - Any cycle of agreement resets that counter.
  - On reaching DB_CYCLES, the debounced level flips and the counter resets.
  - A press event is a one-cycle pulse on the debounced 1->0 transition. Release generates no event.
- State machine (IDLE, RUN, PAUSE):
  - IDLE + run press -> RUN.
  - RUN + run press -> PAUSE.
  - PAUSE + run press -> RUN.
  - Clear press in any state -> IDLE: oDIG=0, prescaler=0. If clear and run press occur in the same cycle, clear wins.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN. At TICK_DIV-1 it wraps to 0 and raises the step strobe.
  - It holds its value in PAUSE, so resume preserves phase, and is zeroed in IDLE.
  - Width is ceil(log2(TICK_DIV)).
  - The first step after IDLE->RUN occurs TICK_DIV cycles after entering RUN.
- Count step:
  - oDIG is registered. The new value and oTICK appear on the clock edge following the prescaler wrap; oTICK and the new oDIG are visible in the same cycle.
  - Up: digit0 increments. A digit at 9 becomes 0 and carries into the next digit.
  - Down: digit0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - Wrap: 99999999 up -> 00000000, or 00000000 down -> 99999999; oWRAP is asserted with that oTICK.
- Direction: the synchronized iUP is sampled on each step. A change takes effect at the next step, with no prescaler reset.
- Invariant: every nibble of oDIG is in 0..9 at all times.
- Pause: oDIG holds its value; oTICK and oWRAP stay 0.

Optional Feature:
- Macro: SEG7_LAP_EN.
- Defined:
  - Adds input iKEY_LAP_N (1 bit, raw, active-low), with the same synchronizer and debounce as the other keys.
  - Lap press in RUN freezes oDIG at the current count while the internal count keeps running. oTICK and oWRAP continue to pulse.
  - A second lap press releases the freeze; oDIG then shows the live count immediately.
  - Lap press in IDLE or PAUSE is ignored, but a freeze already active is kept through PAUSE.
  - Clear releases the freeze.
- Undefined: the port is absent and oDIG always reflects the live count.

Test Plan (TICK_DIV=4, DB_CYCLES=3):
- Assert iRST_N low mid-count with oDIG=0x00000037 -> oDIG=0, oRUN=0, oTICK=0 before the next clock edge; after release, no change for 100 cycles with keys idle.
- Hold iKEY_RUN_N low 10 cycles, iUP=1 -> oRUN=1 exactly 2+3+1 cycles after the falling edge; oTICK every 4 cycles; after 12 oTICKs oDIG=0x00000012; at 0x00000099 the next step gives 0x00000100.
- Glitch iKEY_RUN_N low for 2 cycles -> no press event, oRUN unchanged; glitch low 3 cycles, then high 1 cycle, then low 3 cycles -> exactly one press.
- From IDLE, iUP=0, press run -> first oTICK gives oDIG=0x99999999 with oWRAP=1; next step gives 0x99999998 with oWRAP=0.
- Run to oDIG=0x00000005, press run (pause), wait 50 cycles -> oDIG stays 0x00000005; then press run and clear in the same cycle -> IDLE, oDIG=0, oRUN=0.
- SEG7_LAP_EN: lap press at 0x00000020, wait 8 steps -> oDIG stays 0x00000020 while oTICK pulses 8 times; second lap press -> oDIG=0x00000028.
